food_layer_buffer: RTL and testbench



---
 rtl/food_layer_buffer.sv | 101 ++++++++++
 tb/tb_food_layer_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/food_layer_buffer.sv
// Double-buffered food-layer store: PIO row writes land in a shadow array,
// which is copied to the active array on each vertical-blank rising edge.
module food_layer_buffer #(
    parameter int ROWS  = 32,
    parameter int COLS  = 32,
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [COLS-1:0]  layer_data,
    input  logic [ROW_W-1:0] layer_row,
    input  logic             vblank,
    input  logic             rd_en,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic             rd_data,
    output logic             rd_valid,
    output logic             refresh_image,
    output logic [ROWS-1:0]  dirty_mask
);

    logic [COLS-1:0]  r_shadow [ROWS];
    logic [COLS-1:0]  r_active [ROWS];
    logic [ROW_W-1:0] r_row_q;
    logic [COLS-1:0]  r_data_q;
    logic             r_vblank_q;
    logic [ROWS-1:0]  r_dirty;
    logic             r_rd_data;
    logic             r_rd_valid;
    logic             r_refresh;

    logic             w_commit;
    logic             w_vblank_rise;
    logic [ROWS-1:0]  w_dirty_next;

    assign w_commit      = (layer_row != r_row_q) || (layer_data != r_data_q);
    assign w_vblank_rise = vblank & ~r_vblank_q;

    // Dirty tracking: a copy clears everything, a same-edge commit re-marks its row.
    always_comb begin
        w_dirty_next = w_vblank_rise ? '0 : r_dirty;
        if (w_commit) begin
            w_dirty_next[layer_row] = 1'b1;
        end else begin
            w_dirty_next = w_dirty_next;
        end
    end

    // Bus history and vblank edge detector; vblank_q resets high to avoid a spurious copy.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_row_q    <= '0;
            r_data_q   <= '0;
            r_vblank_q <= 1'b1;
            r_dirty    <= '0;
            r_refresh  <= 1'b0;
        end else begin
            r_row_q    <= layer_row;
            r_data_q   <= layer_data;
            r_vblank_q <= vblank;
            r_dirty    <= w_dirty_next;
            r_refresh  <= w_vblank_rise;
        end
    end

    // Shadow array capture on any PIO bus change.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < ROWS; i++) r_shadow[i] <= '0;
        end else if (w_commit) begin
            r_shadow[layer_row] <= layer_data;
        end
    end

    // Frame copy; non-blocking semantics give the pre-commit shadow contents.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < ROWS; i++) r_active[i] <= '0;
        end else if (w_vblank_rise) begin
            for (int i = 0; i < ROWS; i++) r_active[i] <= r_shadow[i];
        end
    end

    // Single-bit read port, 1-cycle latency; data holds when not reading.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rd_data  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= r_active[rd_row][rd_col];
        end
    end

    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign refresh_image = r_refresh;
    assign dirty_mask    = r_dirty;

endmodule

// File: tb/tb_food_layer_buffer.sv
// Directed self-checking bench for food_layer_buffer.
module tb_food_layer_buffer;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [31:0] layer_data;
    logic [4:0]  layer_row;
    logic        vblank;
    logic        rd_en;
    logic [4:0]  rd_row;
    logic [4:0]  rd_col;
    logic        rd_data;
    logic        rd_valid;
    logic        refresh_image;
    logic [31:0] dirty_mask;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    food_layer_buffer dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .layer_data    (layer_data),
        .layer_row     (layer_row),
        .vblank        (vblank),
        .rd_en         (rd_en),
        .rd_row        (rd_row),
        .rd_col        (rd_col),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .refresh_image (refresh_image),
        .dirty_mask    (dirty_mask)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic do_read(input logic [4:0] r, input logic [4:0] c, input logic exp, input string tag);
        rd_en  = 1'b1;
        rd_row = r;
        rd_col = c;
        step();
        check({tag, "_data"}, {31'd0, rd_data}, {31'd0, exp});
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        rd_en = 1'b0;
    endtask

    task automatic write_row(input logic [4:0] r, input logic [31:0] d);
        layer_row = r;
        step();
        layer_data = d;
        step();
    endtask

    initial begin
        reset_reset = 1'b1;
        layer_data  = 32'd0;
        layer_row   = 5'd0;
        vblank      = 1'b0;
        rd_en       = 1'b0;
        rd_row      = 5'd0;
        rd_col      = 5'd0;
        step();
        step();
        reset_reset = 1'b0;
        step();

        // Reset state and first read
        check("rst_refresh", {31'd0, refresh_image}, 32'd0);
        check("rst_dirty", dirty_mask, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        do_read(5'd7, 5'd3, 1'b0, "rst_rd73");
        check("rst_refresh2", {31'd0, refresh_image}, 32'd0);
        check("rst_dirty2", dirty_mask, 32'd0);
        step();
        check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);

        // Basic write, copy and refresh pulse; read on copy edge sees old data
        write_row(5'd5, 32'h0000_0100);
        check("t2_dirty", dirty_mask, 32'h0000_0020);
        do_read(5'd5, 5'd8, 1'b0, "t2_pre");
        vblank = 1'b1;
        rd_en  = 1'b1;
        step();
        rd_en = 1'b0;
        check("t2_copyedge_rd", {31'd0, rd_data}, 32'd0);
        check("t2_refresh_hi", {31'd0, refresh_image}, 32'd1);
        check("t2_dirty_clr", dirty_mask, 32'd0);
        vblank = 1'b0;
        step();
        check("t2_refresh_lo", {31'd0, refresh_image}, 32'd0);
        do_read(5'd5, 5'd8, 1'b1, "t2_post");

        // Long vblank: one pulse, and a commit during the high phase waits
        vblank = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 10) layer_row = 5'd9;
            if (i == 11) layer_data = 32'h0000_0200;
            step();
            if (refresh_image) pulses++;
        end
        check("t3_pulses", pulses, 32'd1);
        check("t3_dirty", dirty_mask, 32'h0000_0200);
        do_read(5'd9, 5'd9, 1'b0, "t3_notyet");
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        check("t3_refresh2", {31'd0, refresh_image}, 32'd1);
        vblank = 1'b0;
        do_read(5'd9, 5'd9, 1'b1, "t3_copied");

        // Commit and copy on the same edge
        layer_row  = 5'd3;
        layer_data = 32'hFFFF_FFFF;
        vblank     = 1'b1;
        step();
        check("t4_dirty", dirty_mask, 32'h0000_0008);
        check("t4_refresh", {31'd0, refresh_image}, 32'd1);
        vblank = 1'b0;
        do_read(5'd3, 5'd31, 1'b0, "t4_old");
        do_read(5'd3, 5'd0, 1'b0, "t4_old0");
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        check("t4_dirty_clr", dirty_mask, 32'd0);
        do_read(5'd3, 5'd31, 1'b1, "t4_new");

        // All rows, pattern row r = 1<<r
        for (int r = 0; r < 32; r++) write_row(5'(r), 32'd1 << r);
        check("t5_dirty_all", dirty_mask, 32'hFFFF_FFFF);
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        check("t5_dirty_clr", dirty_mask, 32'd0);
        for (int r = 0; r < 32; r++) begin
            do_read(5'(r), 5'(r), 1'b1, $sformatf("t5_diag%0d", r));
            do_read(5'(r), 5'((r + 1) % 32), 1'b0, $sformatf("t5_off%0d", r));
        end

        // Reset mid-frame with a pending pulse; release with vblank high
        write_row(5'd7, 32'h0000_00FF);
        vblank = 1'b1;
        step();
        check("t6_refresh_pre", {31'd0, refresh_image}, 32'd1);
        reset_reset = 1'b1;
        layer_row   = 5'd0;
        layer_data  = 32'd0;
        #1;
        check("t6_async_refresh", {31'd0, refresh_image}, 32'd0);
        check("t6_async_dirty", dirty_mask, 32'd0);
        step();
        step();
        reset_reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (refresh_image) pulses++;
        end
        check("t6_no_pulse", pulses, 32'd0);
        do_read(5'd7, 5'd0, 1'b0, "t6_rd70");
        do_read(5'd5, 5'd8, 1'b0, "t6_rd58");
        do_read(5'd31, 5'd31, 1'b0, "t6_rd3131");
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        check("t6_refresh_after", {31'd0, refresh_image}, 32'd1);
        vblank = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
